// File: rtl/fft_in_buf_if.sv
// Sample-path bundle between the converter, the input buffer and the FFT processor.
// master: the side that supplies samples and reads (converter/processor),
// slave: the buffer itself.
interface fft_in_buf_if #(
    parameter int unsigned NBITS = 23,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic signed [NBITS-1:0] adc_in;
    logic                    adc_vld;
    logic                    req_in;
    logic                    stat_clr;
    logic signed [NBITS-1:0] io_in;
    logic                    itr;
    logic [LW-1:0]           level;
    logic                    ovf;
    logic                    unf;

    modport master (
        output adc_in, adc_vld, req_in, stat_clr,
        input  io_in, itr, level, ovf, unf
    );

    modport slave (
        input  adc_in, adc_vld, req_in, stat_clr,
        output io_in, itr, level, ovf, unf
    );
endinterface

// File: rtl/fft_in_buf.sv
// FFT input buffer: FIFO between the sample converter and the FFT processor, with a
// frame FSM that pulses itr once per FRAME buffered samples and waits for that frame
// to be read before firing again.
// Optional macro FFT_IN_BUF_STAT_EN enables the sticky ovf/unf flags and stat_clr;
// without it ovf/unf read as 0 and stat_clr is ignored.
module fft_in_buf #(
    parameter int unsigned NBITS = 23,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned FRAME = 8
) (
    input logic          clk,
    input logic          rst,
    fft_in_buf_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = (FRAME > 1) ? $clog2(FRAME) : 1;

    typedef enum logic [1:0] {StIdle, StFire, StDrain} state_e;

    logic signed [NBITS-1:0] mem [DEPTH];
    logic [LW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]           level;
    logic                    full, empty, do_wr, do_rd;
    state_e                  state_q;
    logic [CW-1:0]           cnt_q;
    logic                    itr_q;

    // Extra pointer bit makes the difference the true occupancy, 0..DEPTH.
    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    // A read frees a slot in the same cycle, so a full FIFO still accepts a write then.
    assign do_wr = bus.adc_vld && (!full || bus.req_in);
    assign do_rd = bus.req_in && !empty;

    assign bus.level = level;
    assign bus.itr   = itr_q;
    assign bus.io_in = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    // Sample storage; contents need no reset since empty masks io_in.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q[AW-1:0]] <= bus.adc_in;
        end
    end

    // Head/tail pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + LW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + LW'(1);
            end
        end
    end

    // Frame FSM: itr is high exactly while in StFire; reads only count in StDrain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            itr_q   <= 1'b0;
        end else begin
            itr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (level >= LW'(FRAME)) begin
                        state_q <= StFire;
                        itr_q   <= 1'b1;
                    end
                end
                StFire: begin
                    state_q <= StDrain;
                    cnt_q   <= '0;
                end
                StDrain: begin
                    if (do_rd) begin
                        if (cnt_q == CW'(FRAME - 1)) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef FFT_IN_BUF_STAT_EN
    logic ovf_q, unf_q, ovf_set, unf_set;

    assign ovf_set = bus.adc_vld && full && !bus.req_in;
    assign unf_set = bus.req_in && empty;
    assign bus.ovf = ovf_q;
    assign bus.unf = unf_q;

    // Sticky status flags; a same-cycle set wins over stat_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (bus.stat_clr) begin
                ovf_q <= 1'b0;
            end
            if (unf_set) begin
                unf_q <= 1'b1;
            end else if (bus.stat_clr) begin
                unf_q <= 1'b0;
            end
        end
    end
`else
    logic unused_stat_clr;

    assign unused_stat_clr = bus.stat_clr;
    assign bus.ovf = 1'b0;
    assign bus.unf = 1'b0;
`endif
endmodule

// File: tb/tb_fft_in_buf.sv
// Directed bench for fft_in_buf: frame interrupt, overflow/underflow, full-rate
// streaming across pointer wrap and reset mid-frame. Status expectations follow
// whether FFT_IN_BUF_STAT_EN is defined.
module tb_fft_in_buf;
    localparam int unsigned NBITS = 23;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned FRAME = 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

`ifdef FFT_IN_BUF_STAT_EN
    localparam logic STAT = 1'b1;
`else
    localparam logic STAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   itr_total = 0;

    fft_in_buf_if #(.NBITS(NBITS), .DEPTH(DEPTH)) bus ();

    fft_in_buf #(.NBITS(NBITS), .DEPTH(DEPTH), .FRAME(FRAME)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Count cycles with itr high, sampled at the edge that ends them.
    always @(posedge clk) begin
        if (bus.itr === 1'b1) itr_total <= itr_total + 1;
    end

    task automatic cyc(input logic vld, input logic [NBITS-1:0] d, input logic req,
                       input logic clr);
        bus.adc_vld  = vld;
        bus.adc_in   = d;
        bus.req_in   = req;
        bus.stat_clr = clr;
        @(posedge clk);
        #1;
        bus.adc_vld  = 1'b0;
        bus.req_in   = 1'b0;
        bus.stat_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.level !== LW'(0)) begin
            n_fail++; $display("FAIL reset_level: got %0d want 0", bus.level);
        end
        n_checks++;
        if (bus.itr !== 1'b0) begin
            n_fail++; $display("FAIL reset_itr: got %b want 0", bus.itr);
        end
        n_checks++;
        if (bus.io_in !== NBITS'(0)) begin
            n_fail++; $display("FAIL reset_io_in: got %0h want 0", bus.io_in);
        end
        n_checks++;
        if (bus.ovf !== 1'b0 || bus.unf !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got ovf=%b unf=%b want 0 0", bus.ovf, bus.unf);
        end
    endtask

    task automatic test_frame();
        int base;
        do_reset();
        base = itr_total;
        for (int i = 1; i <= 8; i++) cyc(1'b1, NBITS'(i), 1'b0, 1'b0);
        n_checks++;
        if (bus.level !== LW'(8) || bus.itr !== 1'b0) begin
            n_fail++; $display("FAIL frame_fill: got level=%0d itr=%b want 8 0", bus.level, bus.itr);
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (bus.itr !== 1'b1) begin
            n_fail++; $display("FAIL frame_itr_fire: got %b want 1", bus.itr);
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (bus.itr !== 1'b0) begin
            n_fail++; $display("FAIL frame_itr_width: got %b want 0", bus.itr);
        end
        for (int i = 1; i <= 8; i++) begin
            n_checks++;
            if (bus.io_in !== NBITS'(i)) begin
                n_fail++; $display("FAIL frame_data[%0d]: got %0d want %0d", i, bus.io_in, i);
            end
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        n_checks++;
        if (bus.level !== LW'(0)) begin
            n_fail++; $display("FAIL frame_drained: got level=%0d want 0", bus.level);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (itr_total - base !== 1) begin
            n_fail++; $display("FAIL frame_itr_count: got %0d want 1", itr_total - base);
        end
    endtask

    task automatic test_overflow();
        int base;
        do_reset();
        base = itr_total;
        for (int i = 0; i < 16; i++) cyc(1'b1, NBITS'(100 + i), 1'b0, 1'b0);
        n_checks++;
        if (bus.level !== LW'(16) || bus.ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_full: got level=%0d ovf=%b want 16 0", bus.level, bus.ovf);
        end
        cyc(1'b1, NBITS'(999), 1'b0, 1'b0);
        n_checks++;
        if (bus.level !== LW'(16) || bus.ovf !== STAT) begin
            n_fail++;
            $display("FAIL ovf_17th: got level=%0d ovf=%b want 16 %b", bus.level, bus.ovf, STAT);
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (itr_total - base !== 1) begin
            n_fail++; $display("FAIL ovf_single_itr: got %0d want 1", itr_total - base);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (bus.io_in !== NBITS'(100 + i)) begin
                n_fail++; $display("FAIL ovf_data1[%0d]: got %0d want %0d", i, bus.io_in, 100 + i);
            end
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        n_checks++;
        if (bus.itr !== 1'b0) begin
            n_fail++; $display("FAIL ovf_idle_gap: got itr=%b want 0", bus.itr);
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (bus.itr !== 1'b1) begin
            n_fail++; $display("FAIL ovf_refire: got itr=%b want 1", bus.itr);
        end
        for (int i = 8; i < 16; i++) begin
            n_checks++;
            if (bus.io_in !== NBITS'(100 + i)) begin
                n_fail++; $display("FAIL ovf_data2[%0d]: got %0d want %0d", i, bus.io_in, 100 + i);
            end
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        n_checks++;
        if (itr_total - base !== 2 || bus.ovf !== STAT) begin
            n_fail++;
            $display("FAIL ovf_end: got itrs=%0d ovf=%b want 2 %b", itr_total - base, bus.ovf, STAT);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        n_checks++;
        if (bus.io_in !== NBITS'(0)) begin
            n_fail++; $display("FAIL unf_io_in: got %0d want 0", bus.io_in);
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (bus.level !== LW'(0) || bus.unf !== STAT || bus.io_in !== NBITS'(0)) begin
            n_fail++;
            $display("FAIL unf_set: got level=%0d unf=%b io=%0d want 0 %b 0",
                     bus.level, bus.unf, bus.io_in, STAT);
        end
        cyc(1'b0, '0, 1'b0, 1'b1);
        n_checks++;
        if (bus.unf !== 1'b0) begin
            n_fail++; $display("FAIL unf_clr: got %b want 0", bus.unf);
        end
        // Write and read together while empty: write lands, read underflows.
        n_checks++;
        if (bus.io_in !== NBITS'(0)) begin
            n_fail++; $display("FAIL unf_wr_rd_io: got %0d want 0", bus.io_in);
        end
        cyc(1'b1, NBITS'(55), 1'b1, 1'b0);
        n_checks++;
        if (bus.level !== LW'(1) || bus.unf !== STAT || bus.io_in !== NBITS'(55)) begin
            n_fail++;
            $display("FAIL unf_wr_rd: got level=%0d unf=%b io=%0d want 1 %b 55",
                     bus.level, bus.unf, bus.io_in, STAT);
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        // Clear and a fresh underflow in the same cycle: the set wins.
        cyc(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (bus.unf !== STAT || bus.level !== LW'(0)) begin
            n_fail++;
            $display("FAIL unf_set_beats_clr: got unf=%b level=%0d want %b 0", bus.unf, bus.level, STAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [NBITS-1:0] q[$];
        logic [NBITS-1:0] exp;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, NBITS'(200 + i), 1'b0, 1'b0);
            q.push_back(NBITS'(200 + i));
        end
        for (int k = 0; k < 20; k++) begin
            exp = q.pop_front();
            n_checks++;
            if (bus.io_in !== exp) begin
                n_fail++; $display("FAIL b2b_data[%0d]: got %0d want %0d", k, bus.io_in, exp);
            end
            cyc(1'b1, NBITS'(300 + k), 1'b1, 1'b0);
            q.push_back(NBITS'(300 + k));
            n_checks++;
            if (bus.level !== LW'(16)) begin
                n_fail++; $display("FAIL b2b_level[%0d]: got %0d want 16", k, bus.level);
            end
        end
        n_checks++;
        if (bus.ovf !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ovf: got %b want 0", bus.ovf);
        end
    endtask

    task automatic test_rst_mid_frame();
        int base;
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, NBITS'(50 + i), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        base = itr_total;
        rst = 1'b1;
        cyc(1'b1, NBITS'(77), 1'b1, 1'b0);
        rst = 1'b0;
        n_checks++;
        if (bus.level !== LW'(0) || bus.itr !== 1'b0 || bus.io_in !== NBITS'(0)) begin
            n_fail++;
            $display("FAIL rst_mid: got level=%0d itr=%b io=%0d want 0 0 0",
                     bus.level, bus.itr, bus.io_in);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (itr_total !== base) begin
            n_fail++; $display("FAIL rst_no_itr: got %0d want %0d", itr_total, base);
        end
        for (int i = 0; i < 8; i++) cyc(1'b1, NBITS'(60 + i), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (bus.itr !== 1'b1 || bus.io_in !== NBITS'(60)) begin
            n_fail++;
            $display("FAIL rst_refire: got itr=%b io=%0d want 1 60", bus.itr, bus.io_in);
        end
    endtask

    initial begin
        bus.adc_in   = '0;
        bus.adc_vld  = 1'b0;
        bus.req_in   = 1'b0;
        bus.stat_clr = 1'b0;
        test_reset();
        test_frame();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_rst_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_in_buf.md
FFT_IN_BUF -- requirements
Module: fft_in_buf

Interface
REQ-001 SHALL have parameter NBITS, default 23, meaning sample width; it matches processor io_in width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entries; it is a power of two and at least 2*FRAME.
REQ-003 SHALL have parameter FRAME, default 8, meaning samples per FFT frame (2^FFTSIZ).
REQ-004 SHALL have port clk, input, 1, meaning single clock for all logic.
REQ-005 SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-006 SHALL have port adc_in, input, NBITS, meaning signed sample from converter.
REQ-007 SHALL have port adc_vld, input, 1, meaning adc_in is valid this cycle.
REQ-008 SHALL have port req_in, input, 1, meaning processor consumes io_in this cycle.
REQ-009 SHALL have port io_in, output, NBITS, meaning signed head-of-FIFO sample to processor.
REQ-010 SHALL have port itr, output, 1, meaning frame-ready interrupt pulse to processor.
REQ-011 SHALL have port level, output, log2(DEPTH)+1, meaning current occupancy.
REQ-012 SHALL have port ovf, output, 1, meaning sticky write-when-full flag.
REQ-013 SHALL have port unf, output, 1, meaning sticky read-when-empty flag.
REQ-014 SHALL have port stat_clr, input, 1, meaning clears ovf/unf.

Function
REQ-015 SHALL write adc_in into the tail on a rising clk edge with adc_vld=1 and FIFO not full; level updates the next cycle.
REQ-016 SHALL drive io_in as the head entry combinationally from storage, with no added latency, so the processor samples it in the req_in cycle.
REQ-017 SHALL advance the head on a rising clk edge with req_in=1 and FIFO not empty.
REQ-018 SHALL, on req_in while empty, hold io_in at 0, leave pointers unchanged, and set unf.
REQ-019 SHALL, on adc_vld while full without a same-cycle read, drop the sample and set ovf.
REQ-020 SHALL perform both the write and the read on adc_vld with req_in while full; level is unchanged and no ovf.
REQ-021 SHALL perform both the write and the read on adc_vld with req_in while empty; the new sample is not readable that cycle, io_in=0, and unf is set.
REQ-022 SHALL wrap pointers modulo DEPTH, using one extra pointer bit for full/empty discrimination.
REQ-023 SHALL use a frame FSM with states IDLE, FIRE and DRAIN.
REQ-024 SHALL go from IDLE to FIRE when level >= FRAME.
REQ-025 SHALL go from FIRE to DRAIN unconditionally, with the drain counter cleared.
REQ-026 SHALL, in DRAIN, count successful reads and return to IDLE after FRAME reads.
REQ-027 SHALL assert itr high for exactly the single cycle the FSM is in FIRE.
REQ-028 SHALL not issue a second itr until the current frame is fully drained, even if level >= 2*FRAME; re-fire occurs the cycle after return to IDLE.
REQ-029 SHALL accept reads in IDLE; they do not count toward any frame.
REQ-030 SHALL give stat_clr priority below a same-cycle set event, so the flag stays 1.

Reset
REQ-031 SHALL, on rst=1 at a clk edge, clear pointers, level=0, FSM=IDLE, drain counter=0, itr=0, ovf=0, unf=0 and io_in=0.
REQ-032 SHALL give rst priority over all other inputs; rst mid-frame discards buffered data with no itr.
REQ-033 SHALL not require storage contents to be reset.

Configuration
REQ-034 SHALL, with macro FFT_IN_BUF_STAT_EN defined, implement ovf, unf and stat_clr per REQ-018 to REQ-021 and REQ-030.
REQ-035 SHALL, with FFT_IN_BUF_STAT_EN undefined, tie ovf and unf to 0 and ignore stat_clr; data and FSM behaviour are identical.

Verification
REQ-036 SHALL verify: write 8 samples 1..8 with adc_vld -> itr pulses once, 1 cycle, after level reaches 8; 8 req_in reads give 1..8 in order.
REQ-037 SHALL verify: write 16 samples, no reads -> itr once only; 17th write sets ovf, level=16; after 8 reads, a second itr occurs.
REQ-038 SHALL verify: req_in when empty -> io_in=0, level stays 0, unf=1; stat_clr -> unf=0 next cycle.
REQ-039 SHALL verify: full FIFO with adc_vld and req_in together for 20 cycles -> level stays 16, ovf=0, data order preserved across pointer wrap.
REQ-040 SHALL verify: rst asserted after 5 reads of a drained frame -> level=0, itr=0, FSM IDLE; 8 new writes -> normal itr.
REQ-041 SHALL verify: build without FFT_IN_BUF_STAT_EN, overfill and overread -> ovf=unf=0 always, data behaviour unchanged.
